forward_stall_unit: RTL and testbench

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

---
 rtl/fwd_pkg.sv | 15 +
 rtl/fwd_prio_sel.sv | 24 ++
 rtl/forward_stall_unit.sv | 180 ++++++++++++++++++
 tb/tb_forward_stall_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the operand forwarding / load-use stall unit.
package fwd_pkg;

  localparam int DEF_NB_REG_ADDR = 5;
  localparam int DEF_NB_REG      = 32;

  // Architectural zero register: never a forwarding source.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_prio_sel.sv
// Priority encoder over producer-stage match bits; the lowest index (youngest
// producer) wins.
module fwd_prio_sel #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  match,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Scan from oldest to youngest so the youngest match is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit = 1'b1;
        idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/forward_stall_unit.sv
// Decode-stage forwarding select and load-use stall control.
// Optional ID-stage branch-operand forwarding is enabled by defining
// FWD_BRANCH_EN.
module forward_stall_unit
  import fwd_pkg::*;
#(
  parameter int NB_REG_ADDR = DEF_NB_REG_ADDR,
  parameter int NB_REG      = DEF_NB_REG,
  parameter int N_SRC       = 2,
  parameter int N_STG       = 3,
  parameter int LOAD_LAT    = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic                      i_flush,
  input  logic [N_SRC*NB_REG_ADDR-1:0] i_src_addr,
  input  logic [N_SRC-1:0]          i_src_used,
  input  logic [N_STG*NB_REG_ADDR-1:0] i_stg_rd,
  input  logic [N_STG-1:0]          i_stg_we,
  input  logic [N_STG-1:0]          i_stg_load,
  input  logic [N_STG*NB_REG-1:0]   i_stg_data,
  output logic [N_SRC-1:0]          o_fwd_en,
  output logic [N_SRC*NB_REG-1:0]   o_fwd_data,
  output logic                      o_stall,
  output logic                      o_bubble
`ifdef FWD_BRANCH_EN
  ,
  output logic [N_SRC-1:0]          o_br_fwd_en,
  output logic [N_SRC*NB_REG-1:0]   o_br_fwd_data
`endif
);

  localparam int IW = (N_STG > 1) ? $clog2(N_STG) : 1;
  localparam int CW = $clog2(N_STG + 1);

  logic [N_SRC-1:0][N_STG-1:0] match;
  logic [N_SRC-1:0]            hit;
  logic [N_SRC-1:0][IW-1:0]    idx;
  logic [N_SRC-1:0]            haz_any;
  logic [N_SRC-1:0][CW-1:0]    cyc_any;
  logic [N_SRC-1:0][IW-1:0]    sel;
  logic                        hazard;
  logic [CW-1:0]               need;
  state_t                      state, state_nx;
  logic [CW-1:0]               cnt, cnt_nx;

  // Address compare of every source port against every producer stage.
  always_comb begin
    for (int j = 0; j < N_SRC; j++) begin
      for (int k = 0; k < N_STG; k++) begin
        match[j][k] = i_src_used[j] & i_stg_we[k]
          & (i_src_addr[j*NB_REG_ADDR +: NB_REG_ADDR] == i_stg_rd[k*NB_REG_ADDR +: NB_REG_ADDR])
          & (i_src_addr[j*NB_REG_ADDR +: NB_REG_ADDR] != NB_REG_ADDR'(REG_ZERO));
      end
    end
  end

  for (genvar j = 0; j < N_SRC; j++) begin : g_port
    logic          port_haz;
    logic [CW-1:0] port_cyc;

    fwd_prio_sel #(.N(N_STG), .IW(IW)) u_sel (
      .match (match[j]),
      .hit   (hit[j]),
      .idx   (idx[j])
    );

    // A load still short of the stage where its data appears must be waited on.
    assign port_haz = hit[j] & i_stg_load[idx[j]] & (int'(idx[j]) < LOAD_LAT);
    assign port_cyc = CW'(LOAD_LAT - int'(idx[j]));

`ifdef FWD_BRANCH_EN
    logic          br_hit;
    logic [IW-1:0] br_idx;

    // Branch compare happens in ID, so an EX result is not yet available.
    fwd_prio_sel #(.N(N_STG), .IW(IW)) u_br_sel (
      .match (match[j] & ~N_STG'(1)),
      .hit   (br_hit),
      .idx   (br_idx)
    );

    assign o_br_fwd_en[j] = br_hit & ~match[j][0] & ~port_haz;
    assign o_br_fwd_data[j*NB_REG +: NB_REG] = i_stg_data[int'(br_idx)*NB_REG +: NB_REG];
    assign haz_any[j] = port_haz | match[j][0];
    assign cyc_any[j] = port_haz ? port_cyc : CW'(1);
`else
    assign haz_any[j] = port_haz;
    assign cyc_any[j] = port_cyc;
`endif

    assign o_fwd_data[j*NB_REG +: NB_REG] = i_stg_data[int'(sel[j])*NB_REG +: NB_REG];
  end

  // Worst-case stall length across all hazarding ports.
  always_comb begin
    hazard = 1'b0;
    need   = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if (haz_any[j]) begin
        hazard = 1'b1;
        if (cyc_any[j] > need) need = cyc_any[j];
      end
    end
  end

  // State and remaining-stall counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: the first stall cycle is spent in RUN, the rest are counted in STALL.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (i_flush) begin
      state_nx = RUN;
      cnt_nx   = '0;
    end else if (i_valid) begin
      case (state)
        RUN: begin
          if (hazard && need > CW'(1)) begin
            state_nx = STALL;
            cnt_nx   = need - CW'(1);
          end
        end
        STALL: begin
          if (cnt == CW'(1)) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs: stall and bubble always travel together; flush cancels both.
  always_comb begin
    o_stall = 1'b0;
    if (!i_flush) begin
      case (state)
        RUN:     o_stall = hazard & i_valid;
        STALL:   o_stall = 1'b1;
        default: o_stall = 1'b0;
      endcase
    end
    o_bubble = o_stall;
  end

  // Forwarding select captured as the instruction moves into EX; a bubble forwards nothing.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_fwd_en <= '0;
      sel      <= '0;
    end else if (i_flush) begin
      o_fwd_en <= '0;
    end else if (i_valid) begin
      if (o_bubble) begin
        o_fwd_en <= '0;
      end else begin
        o_fwd_en <= hit;
        sel      <= idx;
      end
    end
  end

endmodule

// File: tb/tb_forward_stall_unit.sv
// Directed scoreboard bench for forward_stall_unit (default parameters).
module tb_forward_stall_unit;

  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [14:0] stg_rd;
  logic [2:0]  stg_we, stg_load;
  logic [95:0] stg_data;
  logic [1:0]  fwd_en;
  logic [63:0] fwd_data;
  logic        stall, bubble;

  int tests = 0;
  int fails = 0;

  localparam longint DC = -1;

  typedef struct {
    string  nm;
    longint stall;
    longint en;
    longint d0;
    longint d1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  forward_stall_unit dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_valid    (valid),
    .i_flush    (flush),
    .i_src_addr (src_addr),
    .i_src_used (src_used),
    .i_stg_rd   (stg_rd),
    .i_stg_we   (stg_we),
    .i_stg_load (stg_load),
    .i_stg_data (stg_data),
    .o_fwd_en   (fwd_en),
    .o_fwd_data (fwd_data),
    .o_stall    (stall),
    .o_bubble   (bubble)
  );

  task automatic pr(input int rs, input int rt, input logic [1:0] used,
                    input int r0, input int r1, input int r2,
                    input logic [2:0] we, input logic [2:0] ld);
    src_addr = {5'(rt), 5'(rs)};
    src_used = used;
    stg_rd   = {5'(r2), 5'(r1), 5'(r0)};
    stg_we   = we;
    stg_load = ld;
  endtask

  task automatic expect_out(input string nm, input longint s, input longint en,
                            input longint d0, input longint d1);
    exp_t e;
    e.nm = nm; e.stall = s; e.en = en; e.d0 = d0; e.d1 = d1;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle against the expectation queued for that cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.stall != DC) begin
        tests++;
        if (stall !== 1'(e.stall) || bubble !== 1'(e.stall)) begin
          fails++;
          $display("FAIL %s stall: got stall=%b bubble=%b, expected %0d", e.nm, stall, bubble, e.stall);
        end
      end
      if (e.en != DC) begin
        tests++;
        if (fwd_en !== 2'(e.en)) begin
          fails++;
          $display("FAIL %s fwd_en: got %b, expected %b", e.nm, fwd_en, 2'(e.en));
        end
      end
      if (e.d0 != DC) begin
        tests++;
        if (fwd_data[31:0] !== 32'(e.d0)) begin
          fails++;
          $display("FAIL %s fwd_data0: got %h, expected %h", e.nm, fwd_data[31:0], 32'(e.d0));
        end
      end
      if (e.d1 != DC) begin
        tests++;
        if (fwd_data[63:32] !== 32'(e.d1)) begin
          fails++;
          $display("FAIL %s fwd_data1: got %h, expected %h", e.nm, fwd_data[63:32], 32'(e.d1));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0;
    stg_data = {32'hDEADBEEF, 32'h0000_0022, 32'h0000_0011};
    pr(0, 0, 2'b00, 0, 0, 0, 3'b000, 3'b000);
    tick();
    tick();

    // Reset state
    rst = 1'b0;
    expect_out("reset", 0, 0, 32'h11, 32'h11);
    tick();

    // Youngest producer wins; zero register never forwards
    valid = 1'b1;
    pr(5, 0, 2'b11, 5, 5, 0, 3'b111, 3'b000);
    expect_out("youngest_issue", 0, 0, DC, DC);
    tick();

    // rs from MEM only, rt from WB only
    pr(7, 9, 2'b11, 0, 7, 9, 3'b110, 3'b000);
    expect_out("youngest_fwd", 0, 2'b01, 32'h11, DC);
    tick();

    // valid low: selection holds even though a new match is present
    valid = 1'b0;
    pr(4, 4, 2'b11, 4, 0, 0, 3'b001, 3'b000);
    expect_out("mem_wb_fwd", 0, 2'b11, 32'h22, 32'hDEADBEEF);
    tick();
    expect_out("hold_sel", 0, 2'b11, 32'h22, 32'hDEADBEEF);
    valid = 1'b1;
    pr(4, 4, 2'b00, 4, 0, 0, 3'b001, 3'b000);
    tick();

    // Unused source ports never forward
    valid = 1'b0;
    pr(0, 0, 2'b00, 0, 0, 0, 3'b000, 3'b000);
    expect_out("unused_src", 0, 2'b00, DC, DC);
    tick();

    // Load in EX: two-cycle stall, then forward from WB
    valid = 1'b1;
    pr(8, 0, 2'b01, 8, 0, 0, 3'b001, 3'b001);
    expect_out("ld_ex_s1", 1, 2'b00, DC, DC);
    tick();
    pr(8, 0, 2'b01, 0, 8, 0, 3'b010, 3'b010);
    expect_out("ld_ex_s2", 1, 2'b00, DC, DC);
    tick();
    pr(8, 0, 2'b01, 0, 0, 8, 3'b100, 3'b100);
    expect_out("ld_ex_go", 0, DC, DC, DC);
    tick();
    valid = 1'b0;
    pr(0, 0, 2'b00, 0, 0, 0, 3'b000, 3'b000);
    expect_out("ld_ex_fwd", 0, 2'b01, 32'hDEADBEEF, DC);
    tick();

    // Two ports hazarding (1 and 2 cycles): the longer one decides
    valid = 1'b1;
    pr(3, 6, 2'b11, 6, 3, 0, 3'b011, 3'b011);
    expect_out("dual_s1", 1, DC, DC, DC);
    tick();
    pr(3, 6, 2'b11, 0, 6, 3, 3'b110, 3'b110);
    expect_out("dual_s2", 1, DC, DC, DC);
    tick();
    pr(3, 6, 2'b11, 0, 0, 6, 3'b100, 3'b100);
    expect_out("dual_go", 0, DC, DC, DC);
    tick();
    valid = 1'b0;
    pr(0, 0, 2'b00, 0, 0, 0, 3'b000, 3'b000);
    expect_out("dual_fwd", 0, 2'b10, DC, 32'hDEADBEEF);
    tick();

    // Reset inside the stall aborts it
    valid = 1'b1;
    pr(8, 0, 2'b01, 8, 0, 0, 3'b001, 3'b001);
    expect_out("rst_s1", 1, DC, DC, DC);
    tick();
    rst = 1'b1;
    pr(8, 0, 2'b01, 0, 8, 0, 3'b010, 3'b010);
    expect_out("rst_in_stall", 1, DC, DC, DC);
    tick();
    rst = 1'b0;
    pr(0, 0, 2'b00, 0, 0, 0, 3'b000, 3'b000);
    expect_out("rst_after", 0, 2'b00, DC, DC);
    tick();

    // Flush inside the stall aborts it in the same cycle
    pr(8, 0, 2'b01, 8, 0, 0, 3'b001, 3'b001);
    expect_out("flush_s1", 1, DC, DC, DC);
    tick();
    flush = 1'b1;
    pr(8, 0, 2'b01, 0, 8, 0, 3'b010, 3'b010);
    expect_out("flush_in_stall", 0, DC, DC, DC);
    tick();
    flush = 1'b0;
    pr(8, 0, 2'b01, 0, 0, 8, 3'b100, 3'b100);
    expect_out("flush_after", 0, DC, DC, DC);
    tick();

    // Flush beats a fresh hazard and clears the forward enable
    flush = 1'b1;
    pr(8, 0, 2'b01, 8, 0, 0, 3'b001, 3'b001);
    expect_out("flush_vs_haz", 0, 2'b01, DC, DC);
    tick();
    flush = 1'b0;
    valid = 1'b0;
    pr(0, 0, 2'b00, 0, 0, 0, 3'b000, 3'b000);
    expect_out("flush_clr_en", 0, 2'b00, DC, DC);
    tick();

    // valid low for three cycles mid-stall: stall held, one cycle left afterwards
    valid = 1'b1;
    pr(8, 0, 2'b01, 8, 0, 0, 3'b001, 3'b001);
    expect_out("hold_s1", 1, DC, DC, DC);
    tick();
    valid = 1'b0;
    pr(8, 0, 2'b01, 0, 8, 0, 3'b010, 3'b010);
    for (int i = 0; i < 3; i++) begin
      expect_out("hold_idle", 1, 2'b00, DC, DC);
      tick();
    end
    valid = 1'b1;
    expect_out("hold_last", 1, 2'b00, DC, DC);
    tick();
    pr(8, 0, 2'b01, 0, 0, 8, 3'b100, 3'b100);
    expect_out("hold_go", 0, DC, DC, DC);
    tick();
    valid = 1'b0;
    pr(0, 0, 2'b00, 0, 0, 0, 3'b000, 3'b000);
    expect_out("hold_fwd", 0, 2'b01, 32'hDEADBEEF, DC);
    tick();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
